// File: rtl/fft_frame_feeder.sv
// Input-side framer for the streaming FFT core: groups a real sample stream into
// FRAME_LEN-point frames, buffers them, and drives the Avalon-ST sink handshake.
module fft_frame_feeder #(
    parameter int FRAME_LEN  = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    input  logic        clear_ovf,
    input  logic        fft_ready,
    output logic        fft_valid,
    output logic        fft_sop,
    output logic        fft_eop,
    output logic [15:0] fft_real,
    output logic [15:0] fft_imag,
    output logic [1:0]  fft_error,
    output logic [9:0]  fft_fftpts,
    output logic        fft_inverse,
    output logic        overflow,
    output logic [15:0] frames_sent
);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [15:0] data;
    } beat_t;

    typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    beat_t            wr_beat;
    logic             want, fifo_wr, fifo_rd, drop;

    beat_t            mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_nxt;
    logic             full, empty;
    beat_t            out_q;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write
    // whenever the output register is draining it.
    assign want    = sample_valid && (state == RUN || enable);
    assign fifo_rd = !empty && (!fft_valid || fft_ready);
    assign fifo_wr = want && (!full || fifo_rd);
    assign drop    = want && full && !fifo_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fifo_wr) state_nxt = RUN;
            RUN:     if (fifo_wr && wr_beat.eop && !enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_beat.data = sample_data;
        wr_beat.sop  = 1'b0;
        wr_beat.eop  = 1'b0;
        case (state)
            IDLE: wr_beat.sop = 1'b1;
            RUN: begin
                wr_beat.sop = (idx == '0);
                wr_beat.eop = (idx == LAST_IDX);
            end
            default: wr_beat.sop = 1'b0;
        endcase
    end

    // Dropped samples leave idx untouched so every frame carries FRAME_LEN points.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        idx <= '0;
        else if (fifo_wr) idx <= wr_beat.eop ? '0 : idx + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr] <= wr_beat;
    end

    assign count_nxt = count + (AW+1)'(fifo_wr) - (AW+1)'(fifo_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(FIFO_DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fft_valid <= 1'b0;
            out_q     <= '0;
        end else if (fifo_rd) begin
            fft_valid <= 1'b1;
            out_q     <= mem[rd_ptr];
        end else if (fft_ready) begin
            fft_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  frames_sent <= '0;
        else if (fft_valid && fft_ready && out_q.eop) frames_sent <= frames_sent + 16'd1;
    end

    // A drop in the same cycle as clear_ovf keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (clear_ovf) overflow <= 1'b0;
    end

    assign fft_sop     = out_q.sop;
    assign fft_eop     = out_q.eop;
    assign fft_real    = out_q.data;
    assign fft_imag    = '0;
    assign fft_error   = 2'b00;
    assign fft_fftpts  = 10'(FRAME_LEN);
    assign fft_inverse = 1'b0;

endmodule

// File: doc/fft_frame_feeder.md
# fft_frame_feeder

Input-side framer for the streaming FFT core. Accepts a continuous stream of signed 16-bit real samples from the audio/ADC path and groups them into frames of FRAME_LEN points. It buffers them in a small FIFO and drives the FFT core's Avalon-ST sink handshake with correct sop/eop, fftpts, and inverse. It absorbs FFT backpressure (sink_ready low) up to FIFO depth and reports overflow.

## Interface
- FRAME_LEN, 256: points per frame; power of two, 8..512.
- FIFO_DEPTH, 16: sample FIFO entries; power of two, ≥4.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  start/continue framing; sampled only at frame boundaries.
- sample_valid  in  1  one-cycle strobe, sample_data valid.
- sample_data  in  16  signed two's-complement sample.
- clear_ovf  in  1  pulse, clears overflow.
- fft_ready  in  1  FFT core sink_ready.
- fft_valid  out  1  to FFT sink_valid.
- fft_sop  out  1  to sink_sop; first point of frame.
- fft_eop  out  1  to sink_eop; last point of frame.
- fft_real  out  16  to sink_real; sample_data passthrough.
- fft_imag  out  16  to sink_imag; constant 0.
- fft_error  out  2  to sink_error; constant 2'b00.
- fft_fftpts  out  10  to fftpts_in; constant FRAME_LEN.
- fft_inverse  out  1  to inverse; constant 0 (forward).
- overflow  out  1  sticky; a sample was dropped.
- frames_sent  out  16  count of eop beats accepted by FFT, wraps.

## Operation
- Input framer FSM, states IDLE and RUN, with index counter idx (log2 FRAME_LEN bits):
  - IDLE: samples are discarded (not an overflow). On sample_valid with enable=1, the sample is written with sop=1 and idx=0. The FSM goes to RUN with idx=1.
  - RUN: each accepted sample is written with sop=0 and eop=(idx==FRAME_LEN-1), then idx increments.
  - On writing the eop sample, idx resets to 0. If enable=1, stay RUN, and the next sample gets sop=1. If enable=0, go to IDLE.
  - enable low mid-frame has no effect until the frame completes.
- FIFO entry is 18 bits: {sop, eop, data}. Write occurs on an accepted sample when not full.
- Overflow: sample_valid while the FIFO is full and state is RUN (or IDLE with enable=1):
  - the sample is dropped;
  - idx and state do not advance, so frames always carry exactly FRAME_LEN points;
  - overflow is set.
- clear_ovf clears overflow. If set and clear happen in the same cycle, set wins.
- Output stage: a single output register holds {sop, eop, data}, with fft_valid as its occupancy bit.
  - The register loads from the FIFO head when the FIFO is non-empty and (fft_valid=0 or fft_ready=1).
  - Handshake (ready latency 0): a beat transfers on a cycle with fft_valid=1 and fft_ready=1.
  - While fft_valid=1 and fft_ready=0, fft_valid, fft_sop, fft_eop, and fft_real hold stable.
  - fft_valid never drops without a transfer.
- Full throughput: back-to-back beats at one per cycle when fft_ready stays high.
- frames_sent increments on each transferred beat with fft_eop=1.

## Timing
- Reset values:
  - fft_valid, fft_sop, fft_eop, fft_real, overflow, and frames_sent are all 0.
  - FIFO is empty, FSM is in IDLE, and idx is 0.
  - Constant outputs hold their values during reset.
- Reset mid-frame discards the partial frame and FIFO contents. The FFT core is reset from the same source, so no dangling sop occurs.
- Latency: a sample strobed at edge k into an empty FIFO, with the output register empty, shows fft_valid=1 after edge k+1.
- FIFO full/empty flags are registered; a write and a read in the same cycle on a full FIFO is allowed.
- Sustained backpressure accepts FIFO_DEPTH+1 samples (FIFO plus output register) before the first drop.

## Test plan
- FRAME_LEN=8, enable=1, 16 consecutive samples 0..15, fft_ready=1 -> two frames; sop on 0 and 8, eop on 7 and 15; fft_imag=0; frames_sent=2; overflow=0.
- Samples 100..131 with fft_ready=0 for 20 cycles, then 1 (FIFO_DEPTH=16) -> 17 samples held, samples 117..119 dropped, overflow=1; output is 100..116,120..; eop still every 8th delivered beat; clear_ovf -> overflow=0.
- Randomized fft_ready toggling -> fft_valid/data stable whenever ready=0; output sequence equals input sequence; no duplicates or losses.
- enable deasserted at idx=3 of a frame -> frame completes to eop at idx=7; later samples are discarded with no overflow; re-enable -> next sample gets sop.
- Reset asserted asynchronously mid-frame with 5 entries queued -> all outputs 0 immediately; after release, the first enabled sample carries sop=1.
- clear_ovf in the same cycle as an overflow drop -> overflow stays 1.
